// File: rtl/datapath_control_unit.sv
// Hardwired control sequencer for the datapath.
// Fetch runs in T0-T2 and execute in T3-T7. Every strobe is decoded from the current state and IR.
module datapath_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic        Illegal,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout,
    output logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
    output logic        Read,
    output logic        IncPC,
    output logic [12:0] AluOp
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_ILL, C_HALT, C_ALU, C_IMM, C_UNARY, C_MULDIV, C_LD
    } cls_t;

    localparam int A_AND = 12, A_OR = 11, A_ADD = 10, A_SUB = 9, A_MUL = 8, A_DIV = 7;
    localparam int A_SHR = 6, A_SHRA = 5, A_SHL = 4, A_ROR = 3, A_ROL = 2, A_NEG = 1, A_NOT = 0;

    state_t      state;
    state_t      last_state;
    cls_t        cls;
    logic [12:0] alu;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        unused_ir;

    assign ra_oh     = 16'd1 << IR[26:23];
    assign rb_oh     = 16'd1 << IR[22:19];
    assign rc_oh     = 16'd1 << IR[18:15];
    assign unused_ir = ^IR[14:0];

    always_comb begin
        cls = C_ILL;
        alu = '0;
        case (IR[31:27])
            5'b00000: begin cls = C_LD;     alu[A_ADD]  = 1'b1; end
            5'b00001: begin cls = C_IMM;    alu[A_ADD]  = 1'b1; end
            5'b00011: begin cls = C_ALU;    alu[A_ADD]  = 1'b1; end
            5'b00100: begin cls = C_ALU;    alu[A_SUB]  = 1'b1; end
            5'b00101: begin cls = C_ALU;    alu[A_OR]   = 1'b1; end
            5'b00110: begin cls = C_ALU;    alu[A_AND]  = 1'b1; end
            5'b00111: begin cls = C_ALU;    alu[A_SHR]  = 1'b1; end
            5'b01000: begin cls = C_ALU;    alu[A_SHRA] = 1'b1; end
            5'b01001: begin cls = C_ALU;    alu[A_SHL]  = 1'b1; end
            5'b01010: begin cls = C_ALU;    alu[A_ROR]  = 1'b1; end
            5'b01011: begin cls = C_ALU;    alu[A_ROL]  = 1'b1; end
            5'b01100: begin cls = C_IMM;    alu[A_ADD]  = 1'b1; end
            5'b01101: begin cls = C_IMM;    alu[A_AND]  = 1'b1; end
            5'b01110: begin cls = C_IMM;    alu[A_OR]   = 1'b1; end
            5'b01111: begin cls = C_MULDIV; alu[A_MUL]  = 1'b1; end
            5'b10000: begin cls = C_MULDIV; alu[A_DIV]  = 1'b1; end
            5'b10001: begin cls = C_UNARY;  alu[A_NEG]  = 1'b1; end
            5'b10010: begin cls = C_UNARY;  alu[A_NOT]  = 1'b1; end
            5'b11010: cls = C_NOP;
            5'b11011: cls = C_HALT;
            default:  cls = C_ILL;
        endcase
    end

    always_comb begin
        case (cls)
            C_UNARY:             last_state = S_T4;
            C_ALU, C_IMM:        last_state = S_T5;
            C_MULDIV:            last_state = S_T6;
            C_LD:                last_state = S_T7;
            default:             last_state = S_T3;
        endcase
    end

    // A ">=" test keeps the sequence bounded even if IR changes mid-execute
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET:          state <= S_T0;
                S_HALT:           state <= S_HALT;
                S_T0, S_T1, S_T2: state <= state_t'(state + 4'd1);
                default: begin
                    if (cls == C_HALT)
                        state <= S_HALT;
                    else if (state >= last_state)
                        state <= Stop ? S_HALT : S_T0;
                    else
                        state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end

    always_comb begin
        Run = (state != S_RESET) && (state != S_HALT);
        Illegal = 1'b0;
        Rout = '0; Rin = '0; AluOp = '0;
        HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; IRin = 1'b0;
        Zin = 1'b0; Yin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        Read = 1'b0; IncPC = 1'b0;
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
            S_T1: begin Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: case (cls)
                C_ALU, C_IMM, C_LD: begin Rout = rb_oh; Yin = 1'b1; end
                C_UNARY:            begin Rout = rb_oh; AluOp = alu; Zin = 1'b1; end
                C_MULDIV:           begin Rout = ra_oh; Yin = 1'b1; end
                C_ILL:              Illegal = 1'b1;
                default:            ;
            endcase
            S_T4: case (cls)
                C_ALU:        begin Rout = rc_oh; AluOp = alu; Zin = 1'b1; end
                C_IMM, C_LD:  begin Cout = 1'b1; AluOp = alu; Zin = 1'b1; end
                C_UNARY:      begin Zlowout = 1'b1; Rin = ra_oh; end
                C_MULDIV:     begin Rout = rb_oh; AluOp = alu; Zin = 1'b1; end
                default:      ;
            endcase
            S_T5: case (cls)
                C_ALU, C_IMM: begin Zlowout = 1'b1; Rin = ra_oh; end
                C_MULDIV:     begin Zlowout = 1'b1; LOin = 1'b1; end
                C_LD:         begin Zlowout = 1'b1; MARin = 1'b1; end
                default:      ;
            endcase
            S_T6: case (cls)
                C_MULDIV:     begin Zhighout = 1'b1; HIin = 1'b1; end
                C_LD:         begin Read = 1'b1; MDRin = 1'b1; end
                default:      ;
            endcase
            S_T7: if (cls == C_LD) begin MDRout = 1'b1; Rin = ra_oh; end
            default: ;
        endcase
    end

endmodule
